// File: rtl/datapath_arbiter.sv
// Three-way round-robin arbiter for a shared register/ALU datapath: grants one
// control unit at a time, passes its control word through, and revokes stuck grants.
module datapath_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [10:0] ctl0,
  input  logic [10:0] ctl1,
  input  logic [10:0] ctl2,
  output logic [10:0] ctl_out,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic        timeout,
  output logic        conflict
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      gnt_q, gnt_d;

  logic [10:0]     ctl_sel;
  logic            owner_done;
  logic            expire;
  logic            rd_conflict;
  logic [1:0]      pick;

  // First set request bit at or after ptr, scanning 0-1-2-0.
  function automatic logic [1:0] pick_owner(input logic [2:0] r, input logic [1:0] ptr);
    logic [2:0] sum;
    pick_owner = ptr;
    for (int k = 2; k >= 0; k--) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (r[sum[1:0]]) pick_owner = sum[1:0];
    end
  endfunction

  always_comb begin
    case (owner_q)
      2'd0:    ctl_sel = ctl0;
      2'd1:    ctl_sel = ctl1;
      default: ctl_sel = ctl2;
    endcase
  end

  // gnt_q is one-hot on the owner while a grant is held, so it masks non-owner done.
  assign owner_done  = |(done & gnt_q);
  assign expire      = (cnt_q == CW'(TIMEOUT - 1));
  assign rd_conflict = (ctl_sel[5] & ctl_sel[4]) | (ctl_sel[5] & ctl_sel[3]) |
                       (ctl_sel[5] & ctl_sel[2]) | (ctl_sel[4] & ctl_sel[3]) |
                       (ctl_sel[4] & ctl_sel[2]) | (ctl_sel[3] & ctl_sel[2]);
  assign pick        = pick_owner(req, rr_ptr_q);

  // NOTE: every register uses non-blocking assignment and the async reset sits in
  // the sensitivity list, so reset clears state without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      cnt_q    <= '0;
      gnt_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = pick;
          gnt_d   = 3'b001 << pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (owner_done || expire) begin
          gnt_d   = 3'b000;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        rr_ptr_d = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_out  = '0;
    busy     = 1'b0;
    timeout  = 1'b0;
    conflict = 1'b0;
    case (state_q)
      S_GRANT: busy = 1'b1;
      S_BUSY: begin
        busy     = 1'b1;
        conflict = rd_conflict;
        ctl_out  = rd_conflict ? 11'd0 : ctl_sel;
        timeout  = expire & ~owner_done;
      end
      default: ;
    endcase
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Randomized bench for datapath_arbiter against a grant-age reference model,
// preceded by directed scenarios for latency, fairness, watchdog, conflict and reset.
module tb_datapath_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, done;
  logic [10:0] ctl0, ctl1, ctl2;
  logic [10:0] ctl_out;
  logic [2:0]  gnt;
  logic        busy, timeout, conflict;

  datapath_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .ctl0(ctl0), .ctl1(ctl1), .ctl2(ctl2),
    .ctl_out(ctl_out), .gnt(gnt), .busy(busy), .timeout(timeout), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = none), age = cycles since grant (0 = grant cycle).
  int  m_owner = -1;
  int  m_age = 0;
  int  m_ptr = 0;
  int  m_next_ptr = 0;
  bit  m_release = 1'b0;

  logic [10:0] e_ctl;
  logic [2:0]  e_gnt;
  logic        e_busy, e_to, e_conf;

  int         n_to_seen = 0;
  logic [2:0] obs_gnt;
  logic [2:0] last_gnt = 3'b000;
  logic [2:0] grant_q[$];

  function automatic logic [10:0] word_of(input int o);
    if (o == 0) return ctl0;
    if (o == 1) return ctl1;
    return ctl2;
  endfunction

  task automatic model_expect();
    logic [10:0] w;
    e_ctl = '0; e_gnt = '0; e_busy = 1'b0; e_to = 1'b0; e_conf = 1'b0;
    if (!reset && m_owner >= 0) begin
      e_gnt  = 3'(1 << m_owner);
      e_busy = 1'b1;
      if (m_age >= 1) begin
        w      = word_of(m_owner);
        e_conf = ($countones(w[5:2]) > 1);
        e_ctl  = e_conf ? 11'd0 : w;
        e_to   = (m_age == TIMEOUT) && !done[m_owner];
      end
    end
  endtask

  task automatic model_advance();
    bit found;
    int idx;
    if (reset) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_release = 1'b0;
    end else if (m_owner >= 0 && m_age >= 1 && (done[m_owner] || m_age == TIMEOUT)) begin
      m_next_ptr = (m_owner + 1) % 3;
      m_owner    = -1;
      m_release  = 1'b1;
    end else if (m_owner >= 0) begin
      m_age++;
    end else if (m_release) begin
      m_release = 1'b0;
      m_ptr     = m_next_ptr;
    end else if (req != 3'b000) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_age   = 0;
        end
      end
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    model_expect();
    check("gnt",      32'(gnt),      32'(e_gnt));
    check("ctl_out",  32'(ctl_out),  32'(e_ctl));
    check("busy",     32'(busy),     32'(e_busy));
    check("timeout",  32'(timeout),  32'(e_to));
    check("conflict", 32'(conflict), 32'(e_conf));
    obs_gnt = gnt;
    if (timeout === 1'b1) n_to_seen++;
    if (gnt != 3'b000 && gnt !== last_gnt) grant_q.push_back(gnt);
    last_gnt = gnt;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // NOTE: stimulus is driven with blocking assignments just after the edge, so
    // the DUT samples stable inputs on the following rising edge.
    reset = 1'b1; req = 3'b111; done = 3'b000;
    ctl0 = 11'h7FF; ctl1 = 11'h555; ctl2 = 11'h2AA;
    step();
    step();
    reset = 1'b0;

    // Single requester: owner drops req during BUSY, done[0] at cycle 4.
    req = 3'b000; done = 3'b000; ctl0 = 11'h0A0;
    for (int c = 0; c < 8; c++) begin
      req  = (c <= 1) ? 3'b001 : 3'b000;
      done = (c == 4) ? 3'b001 : 3'b000;
      step();
    end

    // Fairness: all requesting, done always high (non-owner bits ignored).
    do_reset();
    grant_q.delete();
    last_gnt = 3'b000;
    req = 3'b111; done = 3'b111;
    for (int c = 0; c < 18; c++) step();
    check("fair_len", 32'(grant_q.size() >= 4), 32'd1);
    if (grant_q.size() >= 4) begin
      check("fair_0", 32'(grant_q[0]), 32'h1);
      check("fair_1", 32'(grant_q[1]), 32'h2);
      check("fair_2", 32'(grant_q[2]), 32'h4);
      check("fair_3", 32'(grant_q[3]), 32'h1);
    end

    // Watchdog: owner 0 never completes, requester 1 waiting.
    do_reset();
    n_to_seen = 0;
    req = 3'b011; done = 3'b000;
    for (int c = 0; c < 19; c++) step();
    check("wdog_pulses", 32'(n_to_seen), 32'd1);
    req = 3'b010;
    step();
    step();
    check("wdog_next", 32'(obs_gnt), 32'h2);

    // Conflict word, then a legal word, then a non-owner done.
    do_reset();
    ctl0 = 11'h031; req = 3'b001; done = 3'b000;
    step(); step(); step();
    ctl0 = 11'h421; step();
    done = 3'b100; step();
    check("nonowner_done", 32'(obs_gnt), 32'h1);
    done = 3'b001; step();
    done = 3'b000; req = 3'b000; step(); step();

    // Reset pulse in BUSY, then req=110 must go to requester 1.
    req = 3'b001; ctl0 = 11'h0A0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = 3'b110;
    step(); step();
    check("post_reset_gnt", 32'(obs_gnt), 32'h2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      for (int b = 0; b < 3; b++) done[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) ctl0 = 11'($urandom);
      if ($urandom_range(0, 3) == 0) ctl1 = 11'($urandom) & 11'h7C3;
      if ($urandom_range(0, 3) == 0) ctl2 = (11'($urandom) & 11'h7C3) | (11'h004 << $urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
